// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

    // Default width of the divisor and period counter
    localparam int CLK_DIV_CNT_W       = 16;
    // Divisor (full period in clk cycles) loaded at reset
    localparam int CLK_DIV_DEFAULT_DIV = 50;

    // Divisor values with special meaning
    localparam int DIV_HALT   = 0;
    localparam int DIV_BYPASS = 1;

    typedef logic [CLK_DIV_CNT_W-1:0] div_t;

endpackage

// File: rtl/clk_div_shadow.sv
// Pending-divisor slot: accepts one divisor through valid/ready and
// releases it at the next period boundary signalled by the counter.
module clk_div_shadow #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid_i,
    input  logic             boundary_i,
    output logic             div_ready_o,
    output logic             apply_o,
    output logic [CNT_W-1:0] pend_o
);

    logic             pend_vld_q;
    logic             pend_vld_d;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;

    // Next-state of the slot: drain on a boundary, otherwise accept when empty
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        if (pend_vld_q) begin
            // A full slot ignores div_valid; it only empties when applied
            if (boundary_i) begin
                pend_vld_d = 1'b0;
            end else begin
                pend_vld_d = 1'b1;
            end
        end else if (div_valid_i) begin
            pend_vld_d = 1'b1;
            pend_d     = div_i;
        end else begin
            pend_vld_d = 1'b0;
        end
    end

    // Slot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_q     <= {CNT_W{1'b0}};
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    // The boundary test uses the slot state before this edge, so a value
    // accepted on a boundary edge waits for the following boundary.
    assign div_ready_o = ~pend_vld_q;
    assign apply_o     = pend_vld_q & boundary_i;
    assign pend_o      = pend_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided clock plus a one-cycle
// tick at the start of each period. Divisor changes land on boundaries.
module clock_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_act
);

    // The reset divisor must fit in the counter width
    if (longint'(DEFAULT_DIV) < longint'(0) ||
        longint'(DEFAULT_DIV) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_default
        $error("clock_divider_prog: DEFAULT_DIV does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_ZERO = CNT_W'(DIV_HALT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Length of the high phase: ceil(N/2), computed without widening
    function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
        return n - (n >> 1);
    endfunction

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             run_q,     run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;

    logic             last_s;
    logic             boundary_s;
    logic             apply_s;
    logic [CNT_W-1:0] pend_s;
    logic [CNT_W-1:0] new_div_s;
    logic [CNT_W-1:0] cnt_inc_s;

    clk_div_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_i       (div_i),
        .div_valid_i (div_valid),
        .boundary_i  (boundary_s),
        .div_ready_o (div_ready),
        .apply_o     (apply_s),
        .pend_o      (pend_s)
    );

    // Boundary detection and selection of the divisor for the next cycle
    always_comb begin
        cnt_inc_s  = cnt_q + CNT_ONE;
        last_s     = (cnt_q == (div_act_q - CNT_ONE));
        // Idle (en low, halted, not yet started) counts as a boundary every
        // cycle, so a pending divisor never waits on a stopped counter.
        boundary_s = (~en) | (~run_q) | restart | last_s;
        if (apply_s) begin
            new_div_s = pend_s;
        end else begin
            new_div_s = div_act_q;
        end
    end

    // Counter and output decode for the next cycle
    always_comb begin
        cnt_d     = cnt_q;
        run_d     = run_q;
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        div_act_d = new_div_s;
        if (!en) begin
            run_d     = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
            clk_out_d = 1'b0;
            tick_d    = 1'b0;
        end else if (div_act_q == DIV_ZERO) begin
            // Halted: a newly applied divisor starts on the edge after it lands
            run_d     = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
            clk_out_d = 1'b0;
            tick_d    = 1'b0;
        end else if (boundary_s) begin
            if (new_div_s == DIV_ZERO) begin
                run_d     = 1'b0;
                cnt_d     = {CNT_W{1'b0}};
                clk_out_d = 1'b0;
                tick_d    = 1'b0;
            end else begin
                // First cycle of a period is always high (high_len >= 1)
                run_d     = 1'b1;
                cnt_d     = {CNT_W{1'b0}};
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
            end
        end else begin
            run_d     = 1'b1;
            cnt_d     = cnt_inc_s;
            clk_out_d = (cnt_inc_s < high_len(div_act_q));
            tick_d    = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            run_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            div_act_q <= DIV_RST;
        end else begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            div_act_q <= div_act_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_act = div_act_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomized scoreboard bench for clock_divider_prog.
module tb_clock_divider_prog;
    import clk_div_pkg::*;

    localparam int CW = CLK_DIV_CNT_W;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic en        = 1'b0;
    logic restart   = 1'b0;
    logic div_valid = 1'b0;
    div_t div_i     = '0;
    logic div_ready;
    logic clk_out;
    logic tick;
    div_t div_act;

    always #5 clk = ~clk;

    clock_divider_prog #(
        .CNT_W       (CW),
        .DEFAULT_DIV (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .restart   (restart),
        .div_i     (div_i),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .div_act   (div_act)
    );

    typedef struct packed {
        logic          co;
        logic          tk;
        logic          rdy;
        logic [CW-1:0] da;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position inside the current period and divisor slots
    bit running;
    int pos;
    int n_act;
    bit pend_v;
    int pend_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        running = 1'b0;
        pos     = 0;
        n_act   = 50;
        pend_v  = 1'b0;
        pend_n  = 0;
    endtask

    // One clk cycle: drive inputs, predict the state after the edge, queue it
    task automatic step(input bit e, input bit r, input bit v, input int d);
        exp_t x;
        bit   accept;
        bit   at_boundary;
        bit   take;
        int   n_next;
        @(negedge clk);
        en        = e;
        restart   = r;
        div_valid = v;
        div_i     = div_t'(d);
        accept      = v && !pend_v;
        at_boundary = !e || !running || r || (pos == n_act - 1);
        take        = pend_v && at_boundary;
        n_next      = take ? pend_n : n_act;
        if (!e || n_act == DIV_HALT) begin
            running = 1'b0;
            pos     = 0;
        end else if (at_boundary) begin
            running = (n_next != DIV_HALT);
            pos     = 0;
        end else begin
            pos = pos + 1;
        end
        if (take) pend_v = 1'b0;
        if (accept) begin
            pend_v = 1'b1;
            pend_n = d;
        end
        n_act  = n_next;
        x.co   = running && (pos < n_act - n_act / 2);
        x.tk   = running && (pos == 0);
        x.rdy  = !pend_v;
        x.da   = CW'(n_act);
        @(posedge clk);
        #1;
        q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: every cycle the DUT presents a new output state
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_m = q.pop_front();
            check("cycle{clk_out,tick,ready,div_act}",
                  32'({clk_out, tick, div_ready, div_act}), 32'(e_m));
        end
    end

    initial begin
        int guard;
        int r;
        model_reset();
        #12;
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_div_act", 32'(div_act), 32'd50);
        check("reset_div_ready", 32'(div_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divisor, then N=7 loaded mid-period
        run(110);
        step(1'b1, 1'b0, 1'b1, 7);
        run(70);

        // Back to 50, then load 10 at cnt 20; second request must be ignored
        step(1'b1, 1'b0, 1'b1, 50);
        guard = 0;
        while (!(n_act == 50 && running && pos == 19) && guard < 200) begin
            step(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_cnt20: got timeout required position 19");
        end
        step(1'b1, 1'b0, 1'b1, 10);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 33);
        run(60);

        // Bypass, halt, then 4
        step(1'b1, 1'b0, 1'b1, DIV_BYPASS);
        run(15);
        step(1'b1, 1'b0, 1'b1, DIV_HALT);
        run(6);
        step(1'b1, 1'b0, 1'b1, 4);
        run(14);

        // en drop at cnt 3, restart at cnt 6 with N=10
        step(1'b1, 1'b0, 1'b1, 10);
        guard = 0;
        while (!(n_act == 10 && running && pos == 3) && guard < 40) begin
            step(1'b1, 1'b0, 1'b0, 0);
            guard++;
        end
        if (guard >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_cnt3: got timeout required position 3");
        end
        step(1'b0, 1'b0, 1'b0, 0);
        run(7);
        step(1'b1, 1'b1, 1'b0, 0);
        run(12);

        // Async reset in a high phase with a divisor pending
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 20);
        step(1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clk_out", 32'(clk_out), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_div_act", 32'(div_act), 32'd50);
        check("async_div_ready", 32'(div_ready), 32'd1);
        en = 1'b0; restart = 1'b0; div_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(60);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit re;
            bit rr;
            bit rv;
            int rd;
            re = ($urandom_range(0, 99) < 97);
            rr = ($urandom_range(0, 99) < 3);
            rv = ($urandom_range(0, 99) < 10);
            r  = $urandom_range(0, 99);
            if (r < 5)       rd = DIV_HALT;
            else if (r < 10) rd = DIV_BYPASS;
            else if (r < 90) rd = $urandom_range(2, 12);
            else             rd = $urandom_range(13, 60);
            step(re, rr, rv, rd);
        end

        @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d entries left required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
